// File: rtl/cphy_rx_pkg.sv
// Shared types and constants for the C-PHY slave-side lane control FSM.
package cphy_rx_pkg;

    typedef enum logic [4:0] {
        RX_STOP      = 5'd0,
        RX_HS_RQST   = 5'd1,
        RX_HS_SETTLE = 5'd2,
        RX_HS_SYNC   = 5'd3,
        RX_HS_DATA   = 5'd4,
        RX_LP_RQST   = 5'd5,
        RX_LP_YIELD  = 5'd6,
        RX_ESC_RQST  = 5'd7,
        RX_ESC_CMD   = 5'd8,
        RX_LPDT      = 5'd9,
        RX_ULPS      = 5'd10,
        RX_ULPS_EXIT = 5'd11,
        RX_TA_RQST   = 5'd12,
        RX_TA_WAIT   = 5'd13,
        TX_TA_GET    = 5'd14,
        TX_TA_ACK    = 5'd15,
        TX_OWN       = 5'd16,
        RX_WAIT_STOP = 5'd17
    } rx_state_t;

    // Filtered LP line states from the control decoder
    localparam logic [1:0] LP_STOP    = 2'b11;
    localparam logic [1:0] LP_HS_RQST = 2'b01;
    localparam logic [1:0] LP_LP_RQST = 2'b10;
    localparam logic [1:0] LP_BRIDGE  = 2'b00;

    // Escape command types from the escape decoder
    localparam logic [1:0] ESC_LPDT = 2'b00;
    localparam logic [1:0] ESC_ULPS = 2'b01;
    localparam logic [1:0] ESC_TRIG = 2'b10;
    localparam logic [1:0] ESC_INV  = 2'b11;

    // True in the states where this lane drives the LP lines back to the master
    function automatic logic is_tx_state(input rx_state_t s);
        return (s == TX_TA_GET) || (s == TX_TA_ACK) || (s == TX_OWN);
    endfunction

endpackage

// File: rtl/cphy_rx_timer.sv
// Loadable down-counter used to time the fixed-length FSM states.
// done is high whenever the count has reached zero.
module cphy_rx_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load on state change, otherwise count down and stick at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/cphy_rx.sv
// Slave-side C-PHY lane control FSM: decodes LP sequences for HS entry,
// escape entry and bus turnaround, and sequences the receive datapath.
module cphy_rx_fsm
    import cphy_rx_pkg::*;
#(
    parameter int HS_SETTLE    = 5,
    parameter int SYNC_TIMEOUT = 32,
    parameter int TA_SURE      = 3,
    parameter int TA_GET       = 10,
    parameter int TA_ACK       = 5,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] Ctrl_Decoder_Out,
    input  logic       Sync_Detected,
    input  logic       Esc_Cmd_Valid,
    input  logic [1:0] Esc_Cmd_Type,
    input  logic [3:0] Esc_Trigger,
    input  logic       TurnDisable,
    input  logic       TurnRequest,
    output logic       HsTermEn,
    output logic       HsRxEn,
    output logic       Deserializer_En,
    output logic       Esc_Decoder_En,
    output logic       LpTxEn,
    output logic [1:0] TX_Ctrl_Out,
    output logic       RxActiveHS,
    output logic       RxUlpsEsc,
    output logic       RxLpdtEsc,
    output logic       Direction,
    output logic       Stopstate,
    output logic [3:0] RxTriggerEsc,
    output logic       ErrControl,
    output logic       ErrEsc,
    output logic       ErrSotSyncHS
);

    rx_state_t        state_r, state_next;
    logic             timer_done;
    logic             timer_load_s;
    logic [CNT_W-1:0] timer_value_s;
    logic             err_control_s, err_esc_s, err_sync_s;
    logic [3:0]       trigger_s;
    logic             err_control_r, err_esc_r, err_sync_r;
    logic [3:0]       trigger_r;

    cphy_rx_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load_s),
        .value (timer_value_s),
        .done  (timer_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RX_STOP;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic and one-cycle pulse requests
    always_comb begin
        state_next    = state_r;
        err_control_s = 1'b0;
        err_esc_s     = 1'b0;
        err_sync_s    = 1'b0;
        trigger_s     = 4'b0000;
        case (state_r)
            RX_STOP: begin
                case (Ctrl_Decoder_Out)
                    LP_HS_RQST: state_next = RX_HS_RQST;
                    LP_LP_RQST: state_next = RX_LP_RQST;
                    LP_BRIDGE:  begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                    default:    state_next = RX_STOP;
                endcase
            end
            RX_HS_RQST: begin
                case (Ctrl_Decoder_Out)
                    LP_BRIDGE:  state_next = RX_HS_SETTLE;
                    LP_HS_RQST: state_next = RX_HS_RQST;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            // HS states: LP-11 ends the burst ahead of sync and timeout
            RX_HS_SETTLE: begin
                if (Ctrl_Decoder_Out == LP_STOP) state_next = RX_STOP;
                else if (timer_done)             state_next = RX_HS_SYNC;
                else                             state_next = RX_HS_SETTLE;
            end
            RX_HS_SYNC: begin
                if (Ctrl_Decoder_Out == LP_STOP) state_next = RX_STOP;
                else if (Sync_Detected)          state_next = RX_HS_DATA;
                else if (timer_done)             begin state_next = RX_WAIT_STOP; err_sync_s = 1'b1; end
                else                             state_next = RX_HS_SYNC;
            end
            RX_HS_DATA: begin
                if (Ctrl_Decoder_Out == LP_STOP) state_next = RX_STOP;
                else                             state_next = RX_HS_DATA;
            end
            RX_LP_RQST: begin
                case (Ctrl_Decoder_Out)
                    LP_BRIDGE:  state_next = RX_LP_YIELD;
                    LP_LP_RQST: state_next = RX_LP_RQST;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            RX_LP_YIELD: begin
                case (Ctrl_Decoder_Out)
                    LP_HS_RQST: state_next = RX_ESC_RQST;
                    LP_LP_RQST: state_next = RX_TA_RQST;
                    LP_BRIDGE:  state_next = RX_LP_YIELD;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            RX_ESC_RQST: begin
                case (Ctrl_Decoder_Out)
                    LP_BRIDGE:  state_next = RX_ESC_CMD;
                    LP_HS_RQST: state_next = RX_ESC_RQST;
                    LP_STOP:    state_next = RX_STOP;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            // Line toggles while the command shifts in belong to the escape decoder
            RX_ESC_CMD: begin
                if (Ctrl_Decoder_Out == LP_STOP) begin
                    state_next = RX_STOP;
                end else if (Esc_Cmd_Valid) begin
                    case (Esc_Cmd_Type)
                        ESC_LPDT: state_next = RX_LPDT;
                        ESC_ULPS: state_next = RX_ULPS;
                        ESC_TRIG: begin state_next = RX_WAIT_STOP; trigger_s = Esc_Trigger; end
                        ESC_INV:  begin state_next = RX_WAIT_STOP; err_esc_s = 1'b1; end
                        default:  begin state_next = RX_WAIT_STOP; err_esc_s = 1'b1; end
                    endcase
                end else begin
                    state_next = RX_ESC_CMD;
                end
            end
            RX_LPDT: begin
                if (Ctrl_Decoder_Out == LP_STOP) state_next = RX_STOP;
                else                             state_next = RX_LPDT;
            end
            RX_ULPS: begin
                case (Ctrl_Decoder_Out)
                    LP_LP_RQST: state_next = RX_ULPS_EXIT;
                    LP_BRIDGE:  state_next = RX_ULPS;
                    LP_STOP:    state_next = RX_STOP;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            RX_ULPS_EXIT: begin
                case (Ctrl_Decoder_Out)
                    LP_STOP:    state_next = RX_STOP;
                    LP_LP_RQST: state_next = RX_ULPS_EXIT;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            RX_TA_RQST: begin
                case (Ctrl_Decoder_Out)
                    LP_BRIDGE: begin
                        if (TurnDisable) begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                        else             state_next = RX_TA_WAIT;
                    end
                    LP_LP_RQST: state_next = RX_TA_RQST;
                    LP_STOP:    state_next = RX_STOP;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            RX_TA_WAIT: begin
                case (Ctrl_Decoder_Out)
                    LP_BRIDGE: begin
                        if (timer_done) state_next = TX_TA_GET;
                        else            state_next = RX_TA_WAIT;
                    end
                    LP_STOP:    state_next = RX_STOP;
                    default:    begin state_next = RX_WAIT_STOP; err_control_s = 1'b1; end
                endcase
            end
            // While driving the bus the incoming LP state is our own echo and is ignored
            TX_TA_GET: begin
                if (timer_done) state_next = TX_TA_ACK;
                else            state_next = TX_TA_GET;
            end
            TX_TA_ACK: begin
                if (timer_done) state_next = TX_OWN;
                else            state_next = TX_TA_ACK;
            end
            TX_OWN: begin
                if (TurnRequest) state_next = RX_STOP;
                else             state_next = TX_OWN;
            end
            RX_WAIT_STOP: begin
                if (Ctrl_Decoder_Out == LP_STOP) state_next = RX_STOP;
                else                             state_next = RX_WAIT_STOP;
            end
            default: state_next = RX_STOP;
        endcase
    end

    // Timer reload: N-1 for the timed state being entered, on every state change
    always_comb begin
        timer_load_s = (state_next != state_r);
        case (state_next)
            RX_HS_SETTLE: timer_value_s = CNT_W'(HS_SETTLE - 1);
            RX_HS_SYNC:   timer_value_s = CNT_W'(SYNC_TIMEOUT - 1);
            RX_TA_WAIT:   timer_value_s = CNT_W'(TA_SURE - 1);
            TX_TA_GET:    timer_value_s = CNT_W'(TA_GET - 1);
            TX_TA_ACK:    timer_value_s = CNT_W'(TA_ACK - 1);
            default:      timer_value_s = {CNT_W{1'b0}};
        endcase
    end

    // Pulse registers: high for the first cycle of the following state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_control_r <= 1'b0;
            err_esc_r     <= 1'b0;
            err_sync_r    <= 1'b0;
            trigger_r     <= 4'b0000;
        end else begin
            err_control_r <= err_control_s;
            err_esc_r     <= err_esc_s;
            err_sync_r    <= err_sync_s;
            trigger_r     <= trigger_s;
        end
    end

    assign ErrControl   = err_control_r;
    assign ErrEsc       = err_esc_r;
    assign ErrSotSyncHS = err_sync_r;
    assign RxTriggerEsc = trigger_r;

    // Level outputs decoded directly from the current state
    always_comb begin
        HsTermEn        = 1'b0;
        HsRxEn          = 1'b0;
        Deserializer_En = 1'b0;
        RxActiveHS      = 1'b0;
        Esc_Decoder_En  = 1'b0;
        RxLpdtEsc       = 1'b0;
        RxUlpsEsc       = 1'b0;
        TX_Ctrl_Out     = LP_STOP;
        LpTxEn          = is_tx_state(state_r);
        Direction       = ~is_tx_state(state_r);
        Stopstate       = (state_r == RX_STOP) || (state_r == TX_OWN);
        case (state_r)
            RX_HS_SETTLE: HsTermEn = 1'b1;
            RX_HS_SYNC:   begin HsTermEn = 1'b1; HsRxEn = 1'b1; Deserializer_En = 1'b1; end
            RX_HS_DATA:   begin HsTermEn = 1'b1; HsRxEn = 1'b1; Deserializer_En = 1'b1; RxActiveHS = 1'b1; end
            RX_ESC_CMD:   Esc_Decoder_En = 1'b1;
            RX_LPDT:      begin Esc_Decoder_En = 1'b1; RxLpdtEsc = 1'b1; end
            RX_ULPS:      RxUlpsEsc = 1'b1;
            RX_ULPS_EXIT: RxUlpsEsc = 1'b1;
            TX_TA_GET:    TX_Ctrl_Out = LP_BRIDGE;
            TX_TA_ACK:    TX_Ctrl_Out = LP_LP_RQST;
            TX_OWN:       TX_Ctrl_Out = LP_STOP;
            default:      TX_Ctrl_Out = LP_STOP;
        endcase
    end

endmodule

// File: tb/tb_cphy_rx_fsm.sv
// Directed self-checking bench for cphy_rx_fsm.
module tb_cphy_rx_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] lp;
    logic       sync_det, esc_valid, turn_dis, turn_req;
    logic [1:0] esc_type;
    logic [3:0] esc_trig;
    logic       HsTermEn, HsRxEn, Deserializer_En, Esc_Decoder_En, LpTxEn;
    logic [1:0] TX_Ctrl_Out;
    logic       RxActiveHS, RxUlpsEsc, RxLpdtEsc, Direction, Stopstate;
    logic [3:0] RxTriggerEsc;
    logic       ErrControl, ErrEsc, ErrSotSyncHS;
    int         total = 0;
    int         bad = 0;

    cphy_rx_fsm dut (
        .clk(clk), .rst_n(rst_n), .Ctrl_Decoder_Out(lp), .Sync_Detected(sync_det),
        .Esc_Cmd_Valid(esc_valid), .Esc_Cmd_Type(esc_type), .Esc_Trigger(esc_trig),
        .TurnDisable(turn_dis), .TurnRequest(turn_req),
        .HsTermEn(HsTermEn), .HsRxEn(HsRxEn), .Deserializer_En(Deserializer_En),
        .Esc_Decoder_En(Esc_Decoder_En), .LpTxEn(LpTxEn), .TX_Ctrl_Out(TX_Ctrl_Out),
        .RxActiveHS(RxActiveHS), .RxUlpsEsc(RxUlpsEsc), .RxLpdtEsc(RxLpdtEsc),
        .Direction(Direction), .Stopstate(Stopstate), .RxTriggerEsc(RxTriggerEsc),
        .ErrControl(ErrControl), .ErrEsc(ErrEsc), .ErrSotSyncHS(ErrSotSyncHS)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic go_esc();
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        lp = 2'b01; cyc();
        lp = 2'b00; cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lp = 2'b11; sync_det = 1'b0; esc_valid = 1'b0; esc_type = 2'b00;
        esc_trig = 4'b0000; turn_dis = 1'b0; turn_req = 1'b0;
        cyc(); cyc();
        total++; if (Stopstate !== 1'b1) begin bad++; $display("FAIL rst_stopstate got=%b exp=1", Stopstate); end
        total++; if (Direction !== 1'b1) begin bad++; $display("FAIL rst_direction got=%b exp=1", Direction); end
        total++; if (TX_Ctrl_Out !== 2'b11) begin bad++; $display("FAIL rst_txctrl got=%b exp=11", TX_Ctrl_Out); end
        total++; if ({HsTermEn, HsRxEn, Deserializer_En, Esc_Decoder_En, LpTxEn, RxActiveHS, RxUlpsEsc, RxLpdtEsc, ErrControl, ErrEsc, ErrSotSyncHS, RxTriggerEsc} !== 15'd0)
            begin bad++; $display("FAIL rst_others got=nonzero exp=0"); end
        rst_n = 1'b1;
        cyc();
        total++; if (Stopstate !== 1'b1) begin bad++; $display("FAIL rst_release got=%b exp=1", Stopstate); end
    endtask

    task automatic test_hs_burst();
        int n;
        int hi;
        lp = 2'b01; cyc();
        total++; if (Stopstate !== 1'b0) begin bad++; $display("FAIL hs_rqst_stop got=%b exp=0", Stopstate); end
        lp = 2'b00; cyc();
        total++; if (HsTermEn !== 1'b1 || HsRxEn !== 1'b0) begin bad++; $display("FAIL hs_settle got=%b%b exp=10", HsTermEn, HsRxEn); end
        n = 0;
        while (HsRxEn !== 1'b1 && n < 20) begin cyc(); n++; end
        total++; if (n !== 5) begin bad++; $display("FAIL hs_settle_len got=%0d exp=5", n); end
        total++; if (Deserializer_En !== 1'b1 || RxActiveHS !== 1'b0) begin bad++; $display("FAIL hs_sync_out got=%b%b exp=10", Deserializer_En, RxActiveHS); end
        cyc(); cyc();
        sync_det = 1'b1; cyc(); sync_det = 1'b0;
        total++; if (RxActiveHS !== 1'b1) begin bad++; $display("FAIL hs_data got=%b exp=1", RxActiveHS); end
        hi = 0;
        for (int i = 0; i < 20; i++) begin cyc(); if (RxActiveHS === 1'b1) hi++; end
        total++; if (hi !== 20) begin bad++; $display("FAIL hs_data_hold got=%0d exp=20", hi); end
        lp = 2'b11; cyc();
        total++; if (Stopstate !== 1'b1 || HsTermEn !== 1'b0 || RxActiveHS !== 1'b0) begin bad++; $display("FAIL hs_end got=%b%b%b exp=100", Stopstate, HsTermEn, RxActiveHS); end
    endtask

    task automatic test_sync_timeout();
        int n;
        lp = 2'b01; cyc();
        lp = 2'b00; cyc();
        n = 0;
        while (HsRxEn !== 1'b1 && n < 20) begin cyc(); n++; end
        n = 0;
        while (HsRxEn === 1'b1 && n < 100) begin cyc(); n++; end
        total++; if (n !== 32) begin bad++; $display("FAIL sync_to_len got=%0d exp=32", n); end
        total++; if (ErrSotSyncHS !== 1'b1 || Stopstate !== 1'b0) begin bad++; $display("FAIL sync_to_err got=%b%b exp=10", ErrSotSyncHS, Stopstate); end
        cyc();
        total++; if (ErrSotSyncHS !== 1'b0 || Stopstate !== 1'b0) begin bad++; $display("FAIL sync_to_pulse got=%b%b exp=00", ErrSotSyncHS, Stopstate); end
        lp = 2'b11; cyc();
        total++; if (Stopstate !== 1'b1) begin bad++; $display("FAIL sync_to_stop got=%b exp=1", Stopstate); end
    endtask

    task automatic test_priority();
        int n;
        lp = 2'b01; cyc();
        lp = 2'b00; cyc();
        n = 0;
        while (HsRxEn !== 1'b1 && n < 20) begin cyc(); n++; end
        for (int i = 0; i < 31; i++) cyc();
        total++; if (HsRxEn !== 1'b1 || RxActiveHS !== 1'b0) begin bad++; $display("FAIL prio_last_sync got=%b%b exp=10", HsRxEn, RxActiveHS); end
        sync_det = 1'b1; cyc(); sync_det = 1'b0;
        total++; if (RxActiveHS !== 1'b1 || ErrSotSyncHS !== 1'b0) begin bad++; $display("FAIL prio_sync_wins got=%b%b exp=10", RxActiveHS, ErrSotSyncHS); end
        lp = 2'b11; cyc();
        lp = 2'b01; cyc();
        lp = 2'b00; cyc();
        n = 0;
        while (HsRxEn !== 1'b1 && n < 20) begin cyc(); n++; end
        lp = 2'b11; sync_det = 1'b1; cyc(); sync_det = 1'b0;
        total++; if (Stopstate !== 1'b1 || RxActiveHS !== 1'b0) begin bad++; $display("FAIL prio_stop_wins got=%b%b exp=10", Stopstate, RxActiveHS); end
    endtask

    task automatic test_escape();
        go_esc();
        total++; if (Esc_Decoder_En !== 1'b1) begin bad++; $display("FAIL esc_cmd_en got=%b exp=1", Esc_Decoder_En); end
        esc_valid = 1'b1; esc_type = 2'b10; esc_trig = 4'b0001; cyc(); esc_valid = 1'b0;
        total++; if (RxTriggerEsc !== 4'b0001 || Esc_Decoder_En !== 1'b0) begin bad++; $display("FAIL esc_trig got=%b/%b exp=0001/0", RxTriggerEsc, Esc_Decoder_En); end
        cyc();
        total++; if (RxTriggerEsc !== 4'b0000) begin bad++; $display("FAIL esc_trig_pulse got=%b exp=0000", RxTriggerEsc); end
        lp = 2'b11; cyc();
        total++; if (Stopstate !== 1'b1) begin bad++; $display("FAIL esc_trig_stop got=%b exp=1", Stopstate); end
        // LPDT
        go_esc();
        esc_valid = 1'b1; esc_type = 2'b00; cyc(); esc_valid = 1'b0;
        total++; if (RxLpdtEsc !== 1'b1 || Esc_Decoder_En !== 1'b1) begin bad++; $display("FAIL esc_lpdt got=%b%b exp=11", RxLpdtEsc, Esc_Decoder_En); end
        lp = 2'b11; cyc();
        total++; if (RxLpdtEsc !== 1'b0 || Stopstate !== 1'b1) begin bad++; $display("FAIL esc_lpdt_stop got=%b%b exp=01", RxLpdtEsc, Stopstate); end
        // invalid command
        go_esc();
        esc_valid = 1'b1; esc_type = 2'b11; cyc(); esc_valid = 1'b0;
        total++; if (ErrEsc !== 1'b1 || Esc_Decoder_En !== 1'b0) begin bad++; $display("FAIL esc_inv got=%b%b exp=10", ErrEsc, Esc_Decoder_En); end
        cyc();
        total++; if (ErrEsc !== 1'b0) begin bad++; $display("FAIL esc_inv_pulse got=%b exp=0", ErrEsc); end
        lp = 2'b11; cyc();
        // command strobe outside ESC_CMD is ignored
        esc_valid = 1'b1; esc_type = 2'b11; cyc(); esc_valid = 1'b0;
        total++; if (ErrEsc !== 1'b0 || Stopstate !== 1'b1) begin bad++; $display("FAIL esc_ignored got=%b%b exp=01", ErrEsc, Stopstate); end
    endtask

    task automatic test_ulps();
        go_esc();
        esc_valid = 1'b1; esc_type = 2'b01; cyc(); esc_valid = 1'b0;
        total++; if (RxUlpsEsc !== 1'b1) begin bad++; $display("FAIL ulps_entry got=%b exp=1", RxUlpsEsc); end
        cyc();
        total++; if (RxUlpsEsc !== 1'b1) begin bad++; $display("FAIL ulps_hold got=%b exp=1", RxUlpsEsc); end
        lp = 2'b10; cyc();
        total++; if (RxUlpsEsc !== 1'b1 || ErrControl !== 1'b0) begin bad++; $display("FAIL ulps_exit got=%b%b exp=10", RxUlpsEsc, ErrControl); end
        lp = 2'b11; cyc();
        total++; if (RxUlpsEsc !== 1'b0 || Stopstate !== 1'b1) begin bad++; $display("FAIL ulps_stop got=%b%b exp=01", RxUlpsEsc, Stopstate); end
    endtask

    task automatic test_turnaround();
        int n;
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        n = 0;
        while (LpTxEn !== 1'b1 && n < 50) begin cyc(); n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL ta_sure_len got=%0d exp=3", n); end
        n = 0;
        while (LpTxEn === 1'b1 && TX_Ctrl_Out === 2'b00 && n < 50) begin n++; cyc(); end
        total++; if (n !== 10) begin bad++; $display("FAIL ta_get_len got=%0d exp=10", n); end
        n = 0;
        while (LpTxEn === 1'b1 && TX_Ctrl_Out === 2'b10 && n < 50) begin n++; cyc(); end
        total++; if (n !== 5) begin bad++; $display("FAIL ta_ack_len got=%0d exp=5", n); end
        total++; if (TX_Ctrl_Out !== 2'b11 || Direction !== 1'b0 || LpTxEn !== 1'b1 || Stopstate !== 1'b1)
            begin bad++; $display("FAIL ta_own got=%b/%b%b%b exp=11/011", TX_Ctrl_Out, Direction, LpTxEn, Stopstate); end
        lp = 2'b11; cyc(); cyc();
        total++; if (Direction !== 1'b0) begin bad++; $display("FAIL ta_own_hold got=%b exp=0", Direction); end
        turn_req = 1'b1; cyc(); turn_req = 1'b0;
        total++; if (Direction !== 1'b1 || LpTxEn !== 1'b0 || Stopstate !== 1'b1) begin bad++; $display("FAIL ta_return got=%b%b%b exp=101", Direction, LpTxEn, Stopstate); end
    endtask

    task automatic test_errors();
        int n;
        turn_dis = 1'b1;
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        total++; if (ErrControl !== 1'b1 || Stopstate !== 1'b0) begin bad++; $display("FAIL err_turndis got=%b%b exp=10", ErrControl, Stopstate); end
        cyc();
        total++; if (ErrControl !== 1'b0 || LpTxEn !== 1'b0) begin bad++; $display("FAIL err_turndis_pulse got=%b%b exp=00", ErrControl, LpTxEn); end
        lp = 2'b11; cyc();
        turn_dis = 1'b0;
        lp = 2'b00; cyc();
        total++; if (ErrControl !== 1'b1 || Stopstate !== 1'b0) begin bad++; $display("FAIL err_stop00 got=%b%b exp=10", ErrControl, Stopstate); end
        cyc();
        total++; if (ErrControl !== 1'b0) begin bad++; $display("FAIL err_stop00_pulse got=%b exp=0", ErrControl); end
        lp = 2'b11; cyc();
        total++; if (Stopstate !== 1'b1) begin bad++; $display("FAIL err_recover got=%b exp=1", Stopstate); end
        // reset while driving the turnaround
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        lp = 2'b10; cyc();
        lp = 2'b00; cyc();
        n = 0;
        while (LpTxEn !== 1'b1 && n < 50) begin cyc(); n++; end
        total++; if (LpTxEn !== 1'b1 || TX_Ctrl_Out !== 2'b00) begin bad++; $display("FAIL rst_ta_reach got=%b/%b exp=1/00", LpTxEn, TX_Ctrl_Out); end
        rst_n = 1'b0; #1;
        total++; if (LpTxEn !== 1'b0 || Direction !== 1'b1 || TX_Ctrl_Out !== 2'b11 || Stopstate !== 1'b1)
            begin bad++; $display("FAIL rst_mid got=%b%b/%b/%b exp=01/11/1", LpTxEn, Direction, TX_Ctrl_Out, Stopstate); end
        lp = 2'b11; #2; rst_n = 1'b1;
        cyc();
        total++; if (Stopstate !== 1'b1 || LpTxEn !== 1'b0) begin bad++; $display("FAIL rst_mid_release got=%b%b exp=10", Stopstate, LpTxEn); end
    endtask

    initial begin
        test_reset();
        test_hs_burst();
        test_sync_timeout();
        test_priority();
        test_escape();
        test_ulps();
        test_turnaround();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
